button_conditioner: RTL

Front-end conditioner for the board push-buttons. It takes raw, asynchronous, bouncing button inputs and produces per-button clean levels plus one-cycle rising-edge, falling-edge and auto-repeat pulses. The rising-edge vector is the `btn_pedge` bus consumed by the stopwatch and clock-set blocks: bit 0 is start/stop, bit 1 is lap, bit 2 is clear. It sits between the top-level pins and every block that reacts to a button press.

---
 rtl/button_conditioner_if.sv | 33 +++
 rtl/button_conditioner.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - button pin/conditioned-output bundle
// Ports (signals):
//   btn_raw   : raw asynchronous pin levels, active-high
//   btn_level : debounced level per channel
//   btn_pedge : one-cycle pulse on debounced 0->1
//   btn_nedge : one-cycle pulse on debounced 1->0
//   btn_rpt   : one-cycle auto-repeat pulse while held
// master drives the pins, slave is the conditioner.
interface button_conditioner_if #(
  parameter int N_BTN = 3
) ();
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pedge;
  logic [N_BTN-1:0] btn_nedge;
  logic [N_BTN-1:0] btn_rpt;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pedge,
    input  btn_nedge,
    input  btn_rpt
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pedge,
    output btn_nedge,
    output btn_rpt
  );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - push-button synchronizer, debouncer, edge and auto-repeat pulser
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   btn     : button_conditioner_if slave (btn_raw in; btn_level, btn_pedge,
//             btn_nedge, btn_rpt out, all registered)
module button_conditioner #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  button_conditioner_if.slave  btn
);

  localparam int DW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
  localparam bit            RPT_EN     = (REPEAT_DELAY > 0);

  typedef enum logic { IDLE, HOLD }  state_t;
  typedef enum logic { DELAY, RATE } phase_t;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] level_v;
  logic [N_BTN-1:0] pedge_v;
  logic [N_BTN-1:0] nedge_v;
  logic [N_BTN-1:0] rpt_v;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn.btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [DW-1:0] db_cnt;
    logic [DW-1:0] db_cnt_d;
    logic          level;
    logic          level_d;
    logic          pedge;
    logic          pedge_d;
    logic          nedge;
    logic          nedge_d;
    logic          rpt;
    logic          rpt_d;
    state_t        state;
    state_t        state_d;
    phase_t        phase;
    phase_t        phase_d;
    logic [RW-1:0] rpt_cnt;
    logic [RW-1:0] rpt_cnt_d;

    // Debounce: accept sync2 only after DEBOUNCE_CYCLES consecutive
    // mismatching samples; any agreeing sample restarts the count.
    always_comb begin
      db_cnt_d = '0;
      level_d  = level;
      pedge_d  = 1'b0;
      nedge_d  = 1'b0;
      if (sync2[i] != level) begin
        if (db_cnt == DB_LAST) begin
          level_d = sync2[i];
          pedge_d = sync2[i];
          nedge_d = ~sync2[i];
        end else begin
          db_cnt_d = db_cnt + 1'b1;
        end
      end
    end

    // Repeat FSM reacts to the next-state level/edge so that HOLD starts in
    // the btn_pedge cycle and is abandoned in the btn_nedge cycle; this puts
    // the first btn_rpt exactly REPEAT_DELAY cycles after btn_pedge and keeps
    // btn_rpt out of the release cycle.
    always_comb begin
      state_d   = state;
      phase_d   = phase;
      rpt_cnt_d = rpt_cnt;
      rpt_d     = 1'b0;
      if (RPT_EN) begin
        case (state)
          IDLE: begin
            if (pedge_d) begin
              state_d   = HOLD;
              phase_d   = DELAY;
              rpt_cnt_d = '0;
            end
          end
          HOLD: begin
            if (!level_d) begin
              state_d   = IDLE;
              phase_d   = DELAY;
              rpt_cnt_d = '0;
            end else if (phase == DELAY) begin
              if (rpt_cnt == DELAY_LAST) begin
                rpt_d     = 1'b1;
                rpt_cnt_d = '0;
                phase_d   = RATE;
              end else begin
                rpt_cnt_d = rpt_cnt + 1'b1;
              end
            end else begin
              if (rpt_cnt == RATE_LAST) begin
                rpt_d     = 1'b1;
                rpt_cnt_d = '0;
              end else begin
                rpt_cnt_d = rpt_cnt + 1'b1;
              end
            end
          end
          default: begin
            state_d   = IDLE;
            phase_d   = DELAY;
            rpt_cnt_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        db_cnt  <= '0;
        level   <= 1'b0;
        pedge   <= 1'b0;
        nedge   <= 1'b0;
        rpt     <= 1'b0;
        state   <= IDLE;
        phase   <= DELAY;
        rpt_cnt <= '0;
      end else begin
        db_cnt  <= db_cnt_d;
        level   <= level_d;
        pedge   <= pedge_d;
        nedge   <= nedge_d;
        rpt     <= rpt_d;
        state   <= state_d;
        phase   <= phase_d;
        rpt_cnt <= rpt_cnt_d;
      end
    end

    assign level_v[i] = level;
    assign pedge_v[i] = pedge;
    assign nedge_v[i] = nedge;
    assign rpt_v[i]   = rpt;
  end

  assign btn.btn_level = level_v;
  assign btn.btn_pedge = pedge_v;
  assign btn.btn_nedge = nedge_v;
  assign btn.btn_rpt   = rpt_v;

endmodule
